alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Sequential, handshaked execution unit: the responder side of the operand/opcode/result ALU interface.
- Accepts one operation per request on a valid/ready input channel and returns the result on a valid/ready output channel.
- Add, sub, and, or, xor complete in one cycle. Shifts iterate one bit per cycle.
- Sits between the core's issue logic and writeback; it replaces direct combinational use of the ALU where a bounded-area shifter is wanted.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHAMT_W, 5, number of low bits of operand2 used as shift amount (log2 WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request
- operand1  input  WIDTH  first operand
- operand2  input  WIDTH  second operand; low SHAMT_W bits are the shift amount
- opcode  input  4  0001 add, 0010 sub, 0011 and, 0100 or, 0101 xor, 0110 sll, 0111 srl
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- illegal  output  1  registered; high with out_valid when opcode was not 0001-0111

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; in_ready=0 while rst_n low, 1 from the first clk edge after release; out_valid=0, result=0, illegal=0; internal shift count=0.
- Reset mid-operation: in-flight op discarded, no result produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1. Accept on in_valid && in_ready; operands and opcode are captured at that edge.
  - Logic ops (0001-0101): result computed and registered at the accept edge; go to DONE. out_valid rises the next cycle (latency 1).
  - Shift ops (0110/0111): load working register with operand1 and count with operand2[SHAMT_W-1:0].
    - count==0: go to DONE with result=operand1 (latency 1).
    - count!=0: go to SHIFT.
  - Illegal opcode (0000, 1000-1111): result=0, illegal=1; go to DONE (latency 1).
- SHIFT:
  - in_ready=0. Each cycle: shift working register by 1 (sll: left, zero fill; srl: right, logical zero fill); count decrements.
  - When count reaches 0 the final value is in result; go to DONE.
  - Total latency accept-edge to out_valid = shamt+1 cycles. Maximum is 32 for WIDTH=32, shamt=31.
- DONE:
  - out_valid=1, in_ready=0. result and illegal are held stable until out_ready=1.
  - On out_valid && out_ready: out_valid falls, state=IDLE.
  - The next request is accepted no earlier than the following cycle (maximum throughput one op per 2 cycles).
- Arithmetic: add and sub are modulo 2^WIDTH, with no saturation or trap. sub = operand1 - operand2.
- Shift amount uses only operand2[SHAMT_W-1:0]. Upper bits are ignored (shamt 33 behaves as 1).
- Input signals are ignored when in_ready=0. Changes on operand1/operand2/opcode after acceptance have no effect.
- out_ready is ignored when out_valid=0.

Optional Feature:
- Macro: ALU_EXEC_FLAGS_EN.
- When defined: adds outputs zero (1), carry (1), overflow (1). All are registered with result, valid with out_valid, and reset to 0.
  - zero = (result==0).
  - add: carry = carry-out; overflow = signed overflow.
  - sub: carry = carry-out of operand1 + ~operand2 + 1 (1 means no borrow); overflow = signed overflow.
  - sll/srl: carry = last bit shifted out, or 0 if shamt==0; overflow=0.
  - Logic ops and illegal: carry=0, overflow=0.
- When undefined: ports are absent; behaviour is otherwise identical.

Test Plan:
- operand1=50, operand2=10, each opcode 0001-0101, out_ready=1 -> out_valid one cycle after accept. result = 60, 40, 2, 58, 56.
- Sub operand1=10, operand2=50 -> result=0xFFFFFFD8. With ALU_EXEC_FLAGS_EN: carry=0, overflow=0, zero=0.
- sll operand1=50, operand2=10 -> out_valid exactly 11 cycles after accept, result=51200. srl operand1=0x80000000, operand2=31 -> 32 cycles, result=1. srl shamt=0 -> 1 cycle, result=operand1.
- Hold out_ready=0 for 5 cycles in DONE -> result, out_valid, illegal stable; in_ready=0; extra in_valid pulses ignored. Release out_ready -> handshake, then in_ready=1 next cycle.
- opcode=0000 and opcode=1111 -> result=0, illegal=1, latency 1. Next legal op returns illegal=0.
- Start sll shamt=20, pull rst_n low at cycle 7 -> out_valid, result, illegal go to 0 immediately. After release, in_ready=1; add 50+10 returns 60 normally.

Source files
------------

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - handshaked ALU execution unit with bit-serial shifter
//
// Purpose: accepts one operation per valid/ready request and returns the
// registered result on a valid/ready response channel. Add, sub, and, or,
// xor finish in one cycle; sll/srl shift one bit per cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    request handshake
//   operand1, operand2    operands (operand2[SHAMT_W-1:0] is the shift amount)
//   opcode                1 add, 2 sub, 3 and, 4 or, 5 xor, 6 sll, 7 srl
//   out_valid, out_ready  response handshake
//   result                registered result
//   illegal               registered, set when opcode was outside 1..7
//   zero, carry, overflow status flags, present only with ALU_EXEC_FLAGS_EN
//
// Optional feature macro: ALU_EXEC_FLAGS_EN

module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             illegal
`ifdef ALU_EXEC_FLAGS_EN
  ,
  output logic             zero,
  output logic             carry,
  output logic             overflow
`endif
);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               alive;       // low during reset, high from first edge after release
  logic [SHAMT_W-1:0] count;
  logic               shift_left;
  logic               accept;
  logic               is_shift;
  logic [SHAMT_W-1:0] shamt_in;
  logic [WIDTH-1:0]   shifted;

  assign in_ready  = alive && (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_shift  = (opcode == OP_SLL) || (opcode == OP_SRL);
  assign shamt_in  = operand2[SHAMT_W-1:0];
  assign shifted   = shift_left ? (result << 1) : (result >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_shift && (shamt_in != '0)) state_nxt = SHIFT;
          else                              state_nxt = DONE;
        end
      end
      // count still holds the remaining steps including this one
      SHIFT:   if (count == SHAMT_W'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // result doubles as the shift working register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result     <= '0;
      illegal    <= 1'b0;
      count      <= '0;
      shift_left <= 1'b0;
    end else if (accept) begin
      illegal    <= 1'b0;
      count      <= '0;
      shift_left <= 1'b0;
      case (opcode)
        OP_ADD: result <= operand1 + operand2;
        OP_SUB: result <= operand1 - operand2;
        OP_AND: result <= operand1 & operand2;
        OP_OR:  result <= operand1 | operand2;
        OP_XOR: result <= operand1 ^ operand2;
        OP_SLL, OP_SRL: begin
          result     <= operand1;
          count      <= shamt_in;
          shift_left <= (opcode == OP_SLL);
        end
        default: begin
          result  <= '0;
          illegal <= 1'b1;
        end
      endcase
    end else if (state == SHIFT) begin
      result <= shifted;
      count  <= count - SHAMT_W'(1);
    end
  end

`ifdef ALU_EXEC_FLAGS_EN
  logic [WIDTH:0] add_full;
  logic [WIDTH:0] sub_full;
  logic           shift_out;

  assign add_full  = {1'b0, operand1} + {1'b0, operand2};
  assign sub_full  = {1'b0, operand1} + {1'b0, ~operand2} + (WIDTH+1)'(1);
  assign shift_out = shift_left ? result[WIDTH-1] : result[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      carry    <= 1'b0;
      overflow <= 1'b0;
      case (opcode)
        OP_ADD: begin
          zero     <= (add_full[WIDTH-1:0] == '0);
          carry    <= add_full[WIDTH];
          overflow <= (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                      (add_full[WIDTH-1] != operand1[WIDTH-1]);
        end
        OP_SUB: begin
          zero     <= (sub_full[WIDTH-1:0] == '0);
          carry    <= sub_full[WIDTH];
          overflow <= (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                      (sub_full[WIDTH-1] != operand1[WIDTH-1]);
        end
        OP_AND:         zero <= ((operand1 & operand2) == '0);
        OP_OR:          zero <= ((operand1 | operand2) == '0);
        OP_XOR:         zero <= ((operand1 ^ operand2) == '0);
        OP_SLL, OP_SRL: zero <= (operand1 == '0);
        default:        zero <= 1'b1;
      endcase
    end else if (state == SHIFT) begin
      zero  <= (shifted == '0);
      carry <= shift_out;
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit

module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [3:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        illegal;
`ifdef ALU_EXEC_FLAGS_EN
  logic        zero, carry, overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .operand1 (operand1),
    .operand2 (operand2),
    .opcode   (opcode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .illegal  (illegal)
`ifdef ALU_EXEC_FLAGS_EN
    ,
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op, measure latency, optionally stall the response, then complete it.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [31:0] exp_res,
                        input logic exp_ill, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    out_ready = (hold == 0);
    operand1  = a;
    operand2  = b;
    opcode    = op;
    in_valid  = 1'b1;
    check_eq({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    operand1 = ~a;          // post-accept changes must not matter
    operand2 = b + 32'd3;
    opcode   = 4'b0011;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, " result"}, 64'(result), 64'(exp_res));
    check_eq({tag, " illegal"}, 64'(illegal), 64'(exp_ill));
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = 4'b0001;
        @(posedge clk);
        #1;
        check_eq({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, " hold result"}, 64'(result), 64'(exp_res));
        check_eq({tag, " hold illegal"}, 64'(illegal), 64'(exp_ill));
        check_eq({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq({tag, " out_valid after hs"}, 64'(out_valid), 64'd0);
    check_eq({tag, " in_ready after hs"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    operand1  = '0;
    operand2  = '0;
    opcode    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset in_ready", 64'(in_ready), 64'd0);
    check_eq("reset out_valid", 64'(out_valid), 64'd0);
    check_eq("reset result", 64'(result), 64'd0);
    check_eq("reset illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("in_ready before first edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check_eq("in_ready after first edge", 64'(in_ready), 64'd1);

    run_op("add", 32'd50, 32'd10, 4'b0001, 32'd60, 1'b0, 1, 0);
    run_op("sub", 32'd50, 32'd10, 4'b0010, 32'd40, 1'b0, 1, 0);
    run_op("and", 32'd50, 32'd10, 4'b0011, 32'd2,  1'b0, 1, 0);
    run_op("or",  32'd50, 32'd10, 4'b0100, 32'd58, 1'b0, 1, 0);
    run_op("xor", 32'd50, 32'd10, 4'b0101, 32'd56, 1'b0, 1, 0);

    run_op("sub neg", 32'd10, 32'd50, 4'b0010, 32'hFFFF_FFD8, 1'b0, 1, 0);
`ifdef ALU_EXEC_FLAGS_EN
    check_eq("sub neg carry", 64'(carry), 64'd0);
    check_eq("sub neg overflow", 64'(overflow), 64'd0);
    check_eq("sub neg zero", 64'(zero), 64'd0);
`endif

    run_op("sll 10", 32'd50, 32'd10, 4'b0110, 32'd51200, 1'b0, 11, 0);
`ifdef ALU_EXEC_FLAGS_EN
    check_eq("sll 10 carry", 64'(carry), 64'd0);
`endif
    run_op("srl 31", 32'h8000_0000, 32'd31, 4'b0111, 32'd1, 1'b0, 32, 0);
    run_op("srl 0", 32'h1234_5678, 32'd0, 4'b0111, 32'h1234_5678, 1'b0, 1, 0);
    run_op("sll 33", 32'd1, 32'd33, 4'b0110, 32'd2, 1'b0, 2, 0);
    run_op("srl 4", 32'h0000_00F8, 32'd4, 4'b0111, 32'h0000_000F, 1'b0, 5, 0);
`ifdef ALU_EXEC_FLAGS_EN
    check_eq("srl 4 carry", 64'(carry), 64'd1);
`endif

    run_op("hold add", 32'd7, 32'd8, 4'b0001, 32'd15, 1'b0, 1, 5);

    run_op("illegal 0000", 32'd50, 32'd10, 4'b0000, 32'd0, 1'b1, 1, 0);
    run_op("illegal 1111", 32'd50, 32'd10, 4'b1111, 32'd0, 1'b1, 1, 3);
    run_op("legal after illegal", 32'd3, 32'd4, 4'b0001, 32'd7, 1'b0, 1, 0);

`ifdef ALU_EXEC_FLAGS_EN
    run_op("add wrap", 32'hFFFF_FFFF, 32'd1, 4'b0001, 32'd0, 1'b0, 1, 0);
    check_eq("add wrap carry", 64'(carry), 64'd1);
    check_eq("add wrap zero", 64'(zero), 64'd1);
    check_eq("add wrap overflow", 64'(overflow), 64'd0);
    run_op("add ovf", 32'h7FFF_FFFF, 32'd1, 4'b0001, 32'h8000_0000, 1'b0, 1, 0);
    check_eq("add ovf overflow", 64'(overflow), 64'd1);
    check_eq("add ovf carry", 64'(carry), 64'd0);
`endif

    // reset in the middle of a 20-step shift
    @(negedge clk);
    operand1 = 32'd1;
    operand2 = 32'd20;
    opcode   = 4'b0110;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_eq("mid-shift result nonzero", 64'(result != 32'd0), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst result", 64'(result), 64'd0);
    check_eq("midrst illegal", 64'(illegal), 64'd0);
    check_eq("midrst in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post-rst in_ready", 64'(in_ready), 64'd1);
    check_eq("post-rst out_valid", 64'(out_valid), 64'd0);
    run_op("post-rst add", 32'd50, 32'd10, 4'b0001, 32'd60, 1'b0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
